// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receiver and the transmitter.
//   OVERSAMPLE   : s_tick strobes per bit period
//   MID_SAMPLE   : tick count (from the start-bit edge) that lands mid start bit
//   uart_state_t : FSM state encoding; StParity exists only when the build
//                  macro UART_RX_PARITY_EN is defined
`timescale 1ns/1ps
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 7;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset; both flops load 1 (line idle)
//   in    : asynchronous input
//   out   : synchronized output
`timescale 1ns/1ps
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= in;
         r_sync <= r_meta;
      end
   end

   assign out = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling.
// Build option: define UART_RX_PARITY_EN to add a parity bit between the data
// bits and the stop bit, plus the parity_err output.
// Ports:
//   clk          : clock
//   reset        : synchronous active-high reset
//   s_tick       : one-clk strobe at 16x the baud rate
//   rx           : asynchronous serial input, idles high
//   dout         : received data, right-justified, upper bits zero
//   rx_done_tick : one-clk pulse when a frame completes
//   frame_err    : stop bit was sampled low in the last frame
//   parity_err   : parity mismatch in the last frame (parity build only)
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DBIT       = 8,
   parameter int unsigned SB_TICK    = 16,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int unsigned SBW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;

   uart_state_t    r_state;
   logic [3:0]     r_s;
   logic [2:0]     r_n;
   logic [7:0]     r_b;
   logic [SBW-1:0] r_sb_cnt;
   logic [7:0]     r_dout;
   logic           r_done;
   logic           r_ferr;
   // Cleared after a frame whose stop bit was low, so a line held low (break)
   // yields one frame only; set again once the line is seen high.
   logic           r_armed;
   logic           w_rx_s;
   logic [7:0]     w_data;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .in    (rx),
      .out   (w_rx_s)
   );

   // Bits arrive LSB first into the MSB, so short words sit at the top of r_b.
   assign w_data = r_b >> (8 - DBIT);

`ifdef UART_RX_PARITY_EN
   logic r_pbit;
   logic r_perr;
`else
   logic w_unused_parity_odd;
   assign w_unused_parity_odd = PARITY_ODD;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_s      <= '0;
         r_n      <= '0;
         r_b      <= '0;
         r_sb_cnt <= '0;
         r_dout   <= '0;
         r_done   <= 1'b0;
         r_ferr   <= 1'b0;
         r_armed  <= 1'b1;
`ifdef UART_RX_PARITY_EN
         r_pbit   <= 1'b0;
         r_perr   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_rx_s) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state <= StStart;
                  r_s     <= '0;
               end
            end
            StStart: begin
               if (s_tick) begin
                  if (r_s == 4'(MID_SAMPLE)) begin
                     if (!w_rx_s) begin
                        r_state <= StData;
                        r_s     <= '0;
                        r_n     <= '0;
                     end else begin
                        r_state <= StIdle;  // glitch, not a start bit
                     end
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
            StData: begin
               if (s_tick) begin
                  if (r_s == 4'(OVERSAMPLE - 1)) begin
                     r_s <= '0;
                     r_b <= {w_rx_s, r_b[7:1]};
                     if (r_n == 3'(DBIT - 1)) begin
                        r_sb_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        r_state  <= StParity;
`else
                        r_state  <= StStop;
`endif
                     end else begin
                        r_n <= r_n + 3'd1;
                     end
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (s_tick) begin
                  if (r_s == 4'(OVERSAMPLE - 1)) begin
                     r_pbit   <= w_rx_s;
                     r_s      <= '0;
                     r_sb_cnt <= '0;
                     r_state  <= StStop;
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
`endif
            StStop: begin
               if (s_tick) begin
                  if (r_sb_cnt == SBW'(SB_TICK - 1)) begin
                     r_state <= StIdle;
                     r_done  <= 1'b1;
                     r_dout  <= w_data;
                     r_ferr  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                     r_perr  <= (^w_data) ^ r_pbit ^ PARITY_ODD;
`endif
                     if (!w_rx_s) begin
                        r_armed <= 1'b0;
                     end
                  end else begin
                     r_sb_cnt <= r_sb_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign dout         = r_dout;
   assign rx_done_tick = r_done;
   assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = r_perr;
`endif

endmodule
